// File: rtl/mac_pe_pkg.sv
// Shared widths and width helpers for the MAC processing element and the array top.
package pe_pkg;
    localparam int A_W_DEF   = 8;
    localparam int B_W_DEF   = 8;
    localparam int OFF_W_DEF = 9;
    localparam int ACC_W_DEF = 32;

    // b_eff needs one guard bit above the wider of B and offset.
    function automatic int beff_w(input int b_w, input int off_w);
        return ((b_w > off_w) ? b_w : off_w) + 1;
    endfunction

    function automatic int prod_w(input int a_w, input int b_w, input int off_w);
        return a_w + beff_w(b_w, off_w);
    endfunction
endpackage

// File: rtl/mac_pe_if.sv
// Operand, drain-chain and status signals of one PE; slave = PE side, master = driver side.
interface mac_pe_if
    import pe_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic                    clear;
    logic signed [A_W-1:0]   a_in,  a_out;
    logic signed [B_W-1:0]   b_in,  b_out;
    logic signed [OFF_W-1:0] offset;
    logic                    vld_in, last_in, vld_out, last_out;
    logic                    shift_en;
    logic signed [ACC_W-1:0] c_in,  c_out;
    logic                    c_vld_in, c_vld_out;
    logic                    sat_flag, col_err;

    modport slave (
        input  clear, a_in, b_in, offset, vld_in, last_in, shift_en, c_in, c_vld_in,
        output a_out, b_out, vld_out, last_out, c_out, c_vld_out, sat_flag, col_err
    );
    modport master (
        output clear, a_in, b_in, offset, vld_in, last_in, shift_en, c_in, c_vld_in,
        input  a_out, b_out, vld_out, last_out, c_out, c_vld_out, sat_flag, col_err
    );
endinterface

// File: rtl/mac_pe_sat_add.sv
// Accumulate adder: one guard bit of headroom, then either wrap to OUT_W or clamp to its signed range.
module pe_sat_add #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic signed [IN_W-1:0]  i_a,
    input  logic signed [IN_W-1:0]  i_b,
    output logic signed [OUT_W-1:0] o_sum,
    output logic                    o_clip
);
    logic signed [IN_W:0]       w_full;
    logic [IN_W-OUT_W+1:0]      w_top;
    logic                       w_ovf;

    assign w_full = (IN_W+1)'(i_a) + (IN_W+1)'(i_b);
    // Result fits OUT_W only if every bit from the OUT_W sign bit upward agrees.
    assign w_top  = w_full[IN_W:OUT_W-1];
    assign w_ovf  = ~(&w_top) & (|w_top);

    always_comb begin
        o_sum  = w_full[OUT_W-1:0];
        o_clip = 1'b0;
        if (SAT && w_ovf) begin
            o_clip = 1'b1;
            o_sum  = w_full[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/mac_pe.sv
// Output-stationary systolic MAC PE: operand pass-through, accumulator, and a
// double-buffered result register that drains along a neighbour shift chain.
module mac_pe
    import pe_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter bit SAT   = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    mac_pe_if.slave  io
);
    localparam int BE_W  = beff_w(B_W, OFF_W);
    localparam int P_W   = prod_w(A_W, B_W, OFF_W);
    localparam int EXT_W = (ACC_W + 1 > P_W) ? ACC_W + 1 : P_W;

    logic signed [BE_W-1:0]  w_beff;
    logic signed [P_W-1:0]   w_prod;
    logic signed [EXT_W-1:0] w_acc_x, w_prod_x;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_clip, w_capture;

    logic signed [A_W-1:0]   r_a;
    logic signed [B_W-1:0]   r_b;
    logic                    r_vld, r_last;
    logic signed [ACC_W-1:0] r_acc, r_res;
    logic                    r_res_vld, r_sat, r_err;

    assign w_beff    = BE_W'(io.b_in) + BE_W'(io.offset);
    assign w_prod    = P_W'(io.a_in) * P_W'(w_beff);
    assign w_acc_x   = EXT_W'(r_acc);
    assign w_prod_x  = EXT_W'(w_prod);
    assign w_capture = io.vld_in & io.last_in;

    pe_sat_add #(.IN_W(EXT_W), .OUT_W(ACC_W), .SAT(SAT)) u_add (
        .i_a    (w_acc_x),
        .i_b    (w_prod_x),
        .o_sum  (w_sum),
        .o_clip (w_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0; r_b <= '0; r_vld <= 1'b0; r_last <= 1'b0;
            r_acc <= '0; r_res <= '0; r_res_vld <= 1'b0;
            r_sat <= 1'b0; r_err <= 1'b0;
        end else if (io.clear) begin
            r_a <= '0; r_b <= '0; r_vld <= 1'b0; r_last <= 1'b0;
            r_acc <= '0; r_res <= '0; r_res_vld <= 1'b0;
        end else begin
            r_a    <= io.a_in;
            r_b    <= io.b_in;
            r_vld  <= io.vld_in;
            r_last <= io.last_in;
            if (io.vld_in) begin
                r_acc <= io.last_in ? '0 : w_sum;
                if (w_clip) r_sat <= 1'b1;
            end
            // Capture beats the drain; the old result still leaves downstream this cycle.
            if (w_capture) begin
                r_res     <= w_sum;
                r_res_vld <= 1'b1;
                if ((io.shift_en && io.c_vld_in) || (r_res_vld && !io.shift_en))
                    r_err <= 1'b1;
            end else if (io.shift_en) begin
                r_res     <= io.c_in;
                r_res_vld <= io.c_vld_in;
            end
        end
    end

    assign io.a_out     = r_a;
    assign io.b_out     = r_b;
    assign io.vld_out   = r_vld;
    assign io.last_out  = r_last;
    assign io.c_out     = r_res;
    assign io.c_vld_out = r_res_vld;
    assign io.sat_flag  = r_sat;
    assign io.col_err   = r_err;
endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: vector table on a default PE, plus saturation, drain-chain and reset sequences.
module tb_mac_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    mac_pe_if                d_if ();
    mac_pe_if #(.ACC_W(16))  s1_if ();
    mac_pe_if #(.ACC_W(16))  s0_if ();
    mac_pe_if                ch0_if ();
    mac_pe_if                ch1_if ();
    mac_pe_if                ch2_if ();

    mac_pe                           u_d   (.clk(clk), .rst(rst), .io(d_if));
    mac_pe #(.ACC_W(16), .SAT(1'b1)) u_s1  (.clk(clk), .rst(rst), .io(s1_if));
    mac_pe #(.ACC_W(16), .SAT(1'b0)) u_s0  (.clk(clk), .rst(rst), .io(s0_if));
    mac_pe                           u_ch0 (.clk(clk), .rst(rst), .io(ch0_if));
    mac_pe                           u_ch1 (.clk(clk), .rst(rst), .io(ch1_if));
    mac_pe                           u_ch2 (.clk(clk), .rst(rst), .io(ch2_if));

    assign ch1_if.c_in     = ch0_if.c_out;
    assign ch1_if.c_vld_in = ch0_if.c_vld_out;
    assign ch2_if.c_in     = ch1_if.c_out;
    assign ch2_if.c_vld_in = ch1_if.c_vld_out;

    typedef struct {
        logic signed [7:0]  a, b;
        logic signed [8:0]  off;
        logic               vld, last, sh, clr;
        logic signed [31:0] ec;
        logic               ecv, eerr;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(int a, int b, int off, bit v, bit l, bit sh, bit clr,
                                int ec, bit ecv, bit eerr);
        vec_t r;
        r.a = 8'(a); r.b = 8'(b); r.off = 9'(off);
        r.vld = v; r.last = l; r.sh = sh; r.clr = clr;
        r.ec = 32'(ec); r.ecv = ecv; r.eerr = eerr;
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sat(input int a, input int b, input bit v, input bit l, input bit clr);
        s1_if.a_in = 8'(a); s1_if.b_in = 8'(b); s1_if.vld_in = v; s1_if.last_in = l; s1_if.clear = clr;
        s0_if.a_in = 8'(a); s0_if.b_in = 8'(b); s0_if.vld_in = v; s0_if.last_in = l; s0_if.clear = clr;
    endtask

    task automatic set_ch(input int k, input int a, input bit v);
        case (k)
            0:       begin ch0_if.a_in = 8'(a); ch0_if.vld_in = v; ch0_if.last_in = v; end
            1:       begin ch1_if.a_in = 8'(a); ch1_if.vld_in = v; ch1_if.last_in = v; end
            default: begin ch2_if.a_in = 8'(a); ch2_if.vld_in = v; ch2_if.last_in = v; end
        endcase
    endtask

    task automatic shift_ch(input bit s);
        ch0_if.shift_en = s; ch1_if.shift_en = s; ch2_if.shift_en = s;
    endtask

    initial begin
        // Quiet every PE input.
        d_if.clear = 0; d_if.a_in = 0; d_if.b_in = 0; d_if.offset = 0; d_if.vld_in = 0;
        d_if.last_in = 0; d_if.shift_en = 0; d_if.c_in = 0; d_if.c_vld_in = 0;
        set_sat(0, 0, 0, 0, 0);
        s1_if.offset = 0; s1_if.shift_en = 0; s1_if.c_in = 0; s1_if.c_vld_in = 0;
        s0_if.offset = 0; s0_if.shift_en = 0; s0_if.c_in = 0; s0_if.c_vld_in = 0;
        ch0_if.clear = 0; ch1_if.clear = 0; ch2_if.clear = 0;
        ch0_if.b_in = 1; ch1_if.b_in = 1; ch2_if.b_in = 1;
        ch0_if.offset = 0; ch1_if.offset = 0; ch2_if.offset = 0;
        ch0_if.c_in = 0; ch0_if.c_vld_in = 0;
        for (int k = 0; k < 3; k++) set_ch(k, 0, 0);
        shift_ch(0);

        //              a     b    off  v  l  sh clr  c_out   cv err
        tbl[0]  = mk(   1,    5,   0, 1, 0, 0, 0,      0,  0, 0);
        tbl[1]  = mk(  -2,    5,   0, 1, 0, 0, 0,      0,  0, 0);
        tbl[2]  = mk(   3,   -1,   0, 1, 0, 0, 0,      0,  0, 0);
        tbl[3]  = mk( 127, -128,   0, 1, 1, 0, 0, -16264,  1, 0);
        tbl[4]  = mk(   0,    0,   0, 0, 0, 1, 0,      0,  0, 0);
        tbl[5]  = mk(-128,  127, 128, 1, 1, 0, 0, -32640,  1, 0);
        tbl[6]  = mk(   2,    3,   0, 1, 0, 1, 0,      0,  0, 0);
        tbl[7]  = mk(   4,    5,   0, 1, 1, 0, 0,     26,  1, 0);
        tbl[8]  = mk(   1,    1,   0, 1, 0, 1, 0,      0,  0, 0);
        tbl[9]  = mk(   2,   -7,   0, 1, 1, 0, 0,    -13,  1, 0);
        tbl[10] = mk(   1,    1,   0, 1, 1, 0, 0,      1,  1, 1);
        tbl[11] = mk(   5,    5,   0, 1, 0, 0, 0,      1,  1, 1);
        tbl[12] = mk(   5,    5,   0, 1, 0, 0, 0,      1,  1, 1);
        tbl[13] = mk(   9,    9,   0, 1, 1, 0, 1,      0,  0, 1);
        tbl[14] = mk(   2,    3,   0, 1, 1, 0, 0,      6,  1, 1);

        tick(); tick();
        chk("rst_a_out",    d_if.a_out, 0);
        chk("rst_b_out",    d_if.b_out, 0);
        chk("rst_vld_out",  d_if.vld_out, 0);
        chk("rst_last_out", d_if.last_out, 0);
        chk("rst_c_out",    d_if.c_out, 0);
        chk("rst_c_vld",    d_if.c_vld_out, 0);
        chk("rst_sat",      d_if.sat_flag, 0);
        chk("rst_col_err",  d_if.col_err, 0);
        rst = 0;

        for (int i = 0; i < 15; i++) begin
            d_if.a_in = tbl[i].a; d_if.b_in = tbl[i].b; d_if.offset = tbl[i].off;
            d_if.vld_in = tbl[i].vld; d_if.last_in = tbl[i].last;
            d_if.shift_en = tbl[i].sh; d_if.clear = tbl[i].clr;
            tick();
            chk($sformatf("v%0d_c_out", i),    d_if.c_out, tbl[i].ec);
            chk($sformatf("v%0d_c_vld", i),    d_if.c_vld_out, tbl[i].ecv);
            chk($sformatf("v%0d_col_err", i),  d_if.col_err, tbl[i].eerr);
            chk($sformatf("v%0d_a_out", i),    d_if.a_out, tbl[i].clr ? 0 : tbl[i].a);
            chk($sformatf("v%0d_b_out", i),    d_if.b_out, tbl[i].clr ? 0 : tbl[i].b);
            chk($sformatf("v%0d_vld_out", i),  d_if.vld_out, tbl[i].clr ? 0 : tbl[i].vld);
            chk($sformatf("v%0d_last_out", i), d_if.last_out, tbl[i].clr ? 0 : tbl[i].last);
        end
        d_if.vld_in = 0; d_if.last_in = 0; d_if.shift_en = 0; d_if.clear = 0;

        // 16-bit accumulator: 3 x 16129 overflows the signed range.
        set_sat(127, 127, 1, 0, 0); tick();
        tick();
        chk("sat_flag_early", s1_if.sat_flag, 0);
        set_sat(127, 127, 1, 1, 0); tick();
        chk("sat1_c_out", s1_if.c_out, 32767);
        chk("sat1_flag",  s1_if.sat_flag, 1);
        chk("sat0_c_out", s0_if.c_out, -17149);
        chk("sat0_flag",  s0_if.sat_flag, 0);
        set_sat(0, 0, 0, 0, 1); tick();
        chk("sat_clear_flag_held", s1_if.sat_flag, 1);
        chk("sat_clear_c_vld",     s1_if.c_vld_out, 0);
        set_sat(0, 0, 0, 0, 0);

        // Three-PE row drain: load 10/20/30, tail emits 30,20,10 then empties.
        set_ch(0, 10, 1); set_ch(1, 20, 1); set_ch(2, 30, 1); tick();
        for (int k = 0; k < 3; k++) set_ch(k, 0, 0);
        chk("ch_load_tail",  ch2_if.c_out, 30);
        chk("ch_load_vld",   ch2_if.c_vld_out, 1);
        shift_ch(1); tick();
        chk("ch_s1_tail", ch2_if.c_out, 20);
        chk("ch_s1_head_vld", ch0_if.c_vld_out, 0);
        tick();
        chk("ch_s2_tail", ch2_if.c_out, 10);
        chk("ch_s2_vld",  ch2_if.c_vld_out, 1);
        tick();
        chk("ch_s3_vld",  ch2_if.c_vld_out, 0);
        chk("ch_err_clean", ch2_if.col_err, 0);

        // Capture during shift with a valid upstream result drops c_in and flags it.
        shift_ch(0); set_ch(0, 4, 1); tick();
        set_ch(0, 0, 0); set_ch(1, 7, 1); shift_ch(1); tick();
        set_ch(1, 0, 0); shift_ch(0);
        chk("ch_cap_c_out",   ch1_if.c_out, 7);
        chk("ch_cap_col_err", ch1_if.col_err, 1);
        chk("ch_cap_down_vld", ch2_if.c_vld_out, 0);
        chk("ch_cap_head_err", ch0_if.col_err, 0);

        rst = 1; tick();
        chk("rst2_c_out",   d_if.c_out, 0);
        chk("rst2_c_vld",   d_if.c_vld_out, 0);
        chk("rst2_col_err", d_if.col_err, 0);
        chk("rst2_sat",     s1_if.sat_flag, 0);
        chk("rst2_ch_err",  ch1_if.col_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_pe.md
# mac_pe

Parametrised output-stationary systolic processing element, the next generation of the team's 8-bit PE. It adds configurable operand and accumulator widths, valid/last tagging that travels with the operands, and a double-buffered result register. The result register drains through a neighbour-to-neighbour shift chain, and optional saturating accumulation sets a sticky flag. Instances tile into the matrix-multiply array; A flows east, B flows south, and results shift out along the row.

## Interface
- A_W, 8: signed A operand width
- B_W, 8: signed B operand width
- OFF_W, 9: signed B offset width (zero-point correction)
- ACC_W, 32: signed accumulator / result width
- SAT, 0: 1 = saturating accumulate, 0 = two's-complement wrap
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of datapath (see Operation)
- a_in  in  A_W  signed A operand from west
- b_in  in  B_W  signed B operand from north
- offset  in  OFF_W  signed offset added to B; quasi-static per tile
- vld_in  in  1  a_in/b_in valid this cycle
- last_in  in  1  final k-element of tile; qualified by vld_in
- a_out  out  A_W  registered a_in to east
- b_out  out  B_W  registered b_in to south
- vld_out  out  1  registered vld_in
- last_out  out  1  registered last_in
- shift_en  in  1  drain-chain advance (row-wide)
- c_in  in  ACC_W  result from upstream PE in drain chain
- c_vld_in  in  1  c_in valid
- c_out  out  ACC_W  result register
- c_vld_out  out  1  result register holds valid data
- sat_flag  out  1  sticky: accumulation clipped (SAT=1 only; tied 0 otherwise)
- col_err  out  1  sticky: result overwritten before drained

## Operation
- Effective B: b_eff = sign-extended b_in + sign-extended offset, width max(B_W,OFF_W)+1; product p = a_in*b_eff, width A_W+width(b_eff), sign-extended to ACC_W+1 before the add.
- On vld_in=1: sum = acc + p. SAT=0: the result is wrapped to ACC_W. SAT=1: the result is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and sat_flag is set on any clamp.
- vld_in=1, last_in=0: acc <= sum.
- vld_in=1, last_in=1: res <= sum; res_vld <= 1; acc <= 0. The next tile may start the following cycle with no bubble.
- vld_in=0: acc holds. last_in is ignored.
- Drain: shift_en=1 and no capture: res <= c_in; res_vld <= c_vld_in.
- Capture and shift_en in the same cycle: capture wins. The old res is still taken downstream this cycle, and c_in is dropped. col_err is set if c_vld_in=1.
- Capture while res_vld=1 and shift_en=0: res is overwritten and col_err is set.
- clear=1: acc, res, res_vld, and the a/b/vld/last pipeline registers all go to 0. sat_flag and col_err hold. clear overrides vld_in and shift_en.
- rst=1: every register and flag goes to 0. rst overrides clear.

## Timing
- Reset values: a_out=0, b_out=0, vld_out=0, last_out=0, c_out=0, c_vld_out=0, sat_flag=0, col_err=0.
- Operand pass-through: 1 cycle, unconditional. Invalid data also propagates; consumers qualify it with vld_out.
- Result: c_out/c_vld_out update 1 cycle after the vld_in&last_in cycle.
- Drain: one PE hop per shift_en cycle. An N-PE row empties in N shift_en cycles.
- Flags: set on the cycle after the causing event and cleared only by rst.
- rst or clear mid-tile: the partial sum is discarded, and the next vld_in starts from acc=0.
- Single-element tile (first vld_in also last_in): res = p.

## Structure
- Package pe_pkg holds the default widths (A_W, B_W, OFF_W, ACC_W) and a function computing the b_eff and product widths, shared with the array top.
- One sub-module, pe_sat_add: a combinational ACC_W+1 add with wrap/clamp per SAT and a clip indication.
- Everything else (pipeline registers, acc, result register, flags) lives in mac_pe.

## Test plan
- Defaults: 4 valid beats with a={1,-2,3,127}, b={5,5,-1,-128}, offset=0, last on beat 4 -> c_out = 5-10-3-16256 = -16264, c_vld_out=1 one cycle after beat 4; a_out/b_out echo each input one cycle late.
- offset=128, a=-128, b=127, a single last beat -> c_out = -128*255 = -32640.
- SAT=1, ACC_W=16: repeat a=127, b=127 (+16129) three times, last on the third -> c_out=32767, sat_flag=1. With SAT=0, same stimulus -> c_out = 48387-65536 = -17149 and sat_flag=0.
- Back-to-back tiles of 2 beats each (last on beats 2 and 4), with shift_en=1 on the cycle after beat 2 -> c_out carries the first result and then the second; col_err=0. Removing the shift_en pulse -> col_err=1.
- Three-PE chain with results 10, 20, 30 -> under continuous shift_en, the tail c_out emits 30, 20, 10 with c_vld_out=1, then c_vld_out=0.
- clear asserted mid-tile after 2 beats (acc≠0), then a fresh 1-beat tile with a=2, b=3 -> c_out=6. Previously set flags survive clear; rst zeroes all outputs on the next edge.
